// File: rtl/hamming_rx_sequencer_if.sv
// Codeword-in / nibble-out handshake bundle for the Hamming receive sequencer.
// Both channels use valid/ready. A transfer happens on a rising clk edge where valid and ready are both 1.
// The source holds valid and its payload stable until that edge.
// Ready may depend on state only, never combinationally on valid.
interface hamming_rx_sequencer_if #(
  parameter int CW_WIDTH   = 7,
  parameter int DATA_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CW_WIDTH-1:0]   cw_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  link_err;

  modport master (
    output in_valid, cw_in, out_ready,
    input  in_ready, out_valid, out_data, link_err
  );

  modport slave (
    input  in_valid, cw_in, out_ready,
    output in_ready, out_valid, out_data, link_err
  );
endinterface

// File: rtl/hamming_rx_sequencer.sv
// Receive-side Hamming(7,4) sequencer.
// Loads a codeword into the serialiser, reassembles the serial stream, runs the decoder once and hands out the nibble.
module hamming_rx_sequencer #(
  parameter int CW_WIDTH   = 7,
  parameter int DATA_WIDTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  hamming_rx_sequencer_if.slave bus,
  output logic                  pts_reset,
  output logic                  pts_write,
  output logic                  pts_shift,
  output logic [CW_WIDTH-1:0]   pts_data,
  input  logic                  serial_in,
  output logic                  dec_enable,
  output logic [CW_WIDTH-1:0]   dec_codeword,
  input  logic [DATA_WIDTH-1:0] dec_data,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = (CW_WIDTH > 1) ? $clog2(CW_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    DECODE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      shift_idx;
  logic [CW_WIDTH-1:0]   cw_reg;
  logic [CW_WIDTH-1:0]   asm_reg;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  link_err_q;
  logic                  out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_CNT) state_next = DECODE;
      DECODE:  state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // The serial position of the current bit maps to a codeword index according to the wire order.
  always_comb begin
    shift_idx = bit_cnt;
    if (MSB_FIRST) shift_idx = LAST_CNT - bit_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      cw_reg      <= '0;
      asm_reg     <= '0;
      out_data_q  <= '0;
      link_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      bit_cnt     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) cw_reg <= bus.cw_in;
        end
        LOAD: begin
          bit_cnt <= '0;
        end
        SHIFT: begin
          asm_reg[shift_idx] <= serial_in;
          if (bit_cnt != LAST_CNT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
        DECODE: begin
          out_data_q  <= dec_data;
          link_err_q  <= (asm_reg != cw_reg);
          out_valid_q <= 1'b1;
        end
        HOLD: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are pure state decodes so the shifter and decoder see them in the same cycle as the state.
  assign bus.in_ready  = (state == IDLE);
  assign pts_reset     = (state == IDLE);
  assign pts_write     = (state == LOAD);
  assign pts_shift     = (state == SHIFT);
  assign dec_enable    = (state == DECODE);
  assign busy          = (state != IDLE);
  assign pts_data      = cw_reg;
  assign dec_codeword  = asm_reg;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.link_err  = link_err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// Directed bench for hamming_rx_sequencer: an MSB-first instance with a fault-injectable loopback shifter, and an LSB-first instance.
module tb_hamming_rx_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fault_bit = -1;

  // MSB-first instance
  hamming_rx_sequencer_if #(.CW_WIDTH(7), .DATA_WIDTH(4)) bus_a ();
  logic       pts_reset_a, pts_write_a, pts_shift_a, serial_in_a, dec_enable_a, busy_a;
  logic [6:0] pts_data_a, dec_codeword_a;
  logic [3:0] dec_data_a;
  logic [2:0] state_dbg_a;

  hamming_rx_sequencer #(.CW_WIDTH(7), .DATA_WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_a),
    .pts_reset(pts_reset_a), .pts_write(pts_write_a), .pts_shift(pts_shift_a),
    .pts_data(pts_data_a), .serial_in(serial_in_a), .dec_enable(dec_enable_a),
    .dec_codeword(dec_codeword_a), .dec_data(dec_data_a), .busy(busy_a),
    .state_dbg(state_dbg_a)
  );

  // LSB-first instance
  hamming_rx_sequencer_if #(.CW_WIDTH(7), .DATA_WIDTH(4)) bus_b ();
  logic       pts_reset_b, pts_write_b, pts_shift_b, serial_in_b, dec_enable_b, busy_b;
  logic [6:0] pts_data_b, dec_codeword_b;
  logic [3:0] dec_data_b;
  logic [2:0] state_dbg_b;

  hamming_rx_sequencer #(.CW_WIDTH(7), .DATA_WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(1'b0), .bus(bus_b),
    .pts_reset(pts_reset_b), .pts_write(pts_write_b), .pts_shift(pts_shift_b),
    .pts_data(pts_data_b), .serial_in(serial_in_b), .dec_enable(dec_enable_b),
    .dec_codeword(dec_codeword_b), .dec_data(dec_data_b), .busy(busy_b),
    .state_dbg(state_dbg_b)
  );

  // Hamming(7,4) decoder: bit i holds position i+1; parity at positions 1,2,4.
  function automatic logic [3:0] ham_dec(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] f;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    f = c;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    return {f[6], f[5], f[4], f[2]};
  endfunction

  assign dec_data_a = ham_dec(dec_codeword_a);
  assign dec_data_b = ham_dec(dec_codeword_b);

  // Loopback parallel-to-serial shifters
  logic [6:0] sh_a, sh_b;
  int sh_cnt_a;
  always @(posedge clk) begin
    if (pts_reset_a) begin
      sh_a <= '0; sh_cnt_a <= 0;
    end else if (pts_write_a) begin
      sh_a <= pts_data_a; sh_cnt_a <= 0;
    end else if (pts_shift_a) begin
      sh_a <= sh_a << 1; sh_cnt_a <= sh_cnt_a + 1;
    end
  end
  assign serial_in_a = sh_a[6] ^ (fault_bit == (6 - sh_cnt_a));

  always @(posedge clk) begin
    if (pts_reset_b)      sh_b <= '0;
    else if (pts_write_b) sh_b <= pts_data_b;
    else if (pts_shift_b) sh_b <= sh_b >> 1;
  end
  assign serial_in_b = sh_b[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Entered in the LOAD cycle (cycle 1); returns in the first out_valid cycle (cycle 10).
  task automatic track_word(input logic [6:0] exp_pts, input logic [6:0] exp_asm,
                            input logic [3:0] exp_data, input logic exp_err);
    chk("load_write", pts_write_a, 1);
    chk("load_data", pts_data_a, exp_pts);
    chk("load_in_ready", bus_a.in_ready, 0);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk("shift_strobe", pts_shift_a, 1);
      chk("shift_no_write", pts_write_a, 0);
      chk("shift_no_dec", dec_enable_a, 0);
    end
    step();
    chk("dec_enable", dec_enable_a, 1);
    chk("dec_codeword", dec_codeword_a, exp_asm);
    chk("dec_no_valid", bus_a.out_valid, 0);
    step();
    chk("out_valid", bus_a.out_valid, 1);
    chk("out_data", bus_a.out_data, exp_data);
    chk("link_err", bus_a.link_err, exp_err);
    chk("hold_in_ready", bus_a.in_ready, 0);
  endtask

  logic [6:0] b2b_cw   [4] = '{7'b0000111, 7'b1001100, 7'b0110011, 7'b1111111};
  logic [3:0] b2b_data [4] = '{4'b0001, 4'b1001, 4'b0110, 4'b1111};
  int t0;

  initial begin
    bus_a.in_valid = 0; bus_a.cw_in = '0; bus_a.out_ready = 1;
    bus_b.in_valid = 0; bus_b.cw_in = '0; bus_b.out_ready = 1;
    step(); step();
    reset = 0;

    // Reset state
    chk("rst_in_ready", bus_a.in_ready, 1);
    chk("rst_pts_reset", pts_reset_a, 1);
    chk("rst_pts_write", pts_write_a, 0);
    chk("rst_pts_shift", pts_shift_a, 0);
    chk("rst_dec_enable", dec_enable_a, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_data", bus_a.out_data, 0);
    chk("rst_link_err", bus_a.link_err, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pts_data", pts_data_a, 0);

    // Single word, ideal loopback
    bus_a.in_valid = 1; bus_a.cw_in = 7'b1010101;
    step();
    bus_a.in_valid = 0;
    track_word(7'b1010101, 7'b1010101, 4'b1011, 1'b0);
    step();
    chk("t1_idle_ready", bus_a.in_ready, 1);
    chk("t1_valid_drop", bus_a.out_valid, 0);

    // Backpressure with a second word waiting
    bus_a.out_ready = 0; bus_a.in_valid = 1; bus_a.cw_in = 7'b0000111;
    step();
    bus_a.cw_in = 7'b1111111;
    track_word(7'b0000111, 7'b0000111, 4'b0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_valid", bus_a.out_valid, 1);
      chk("bp_data", bus_a.out_data, 4'b0001);
      chk("bp_err", bus_a.link_err, 0);
      chk("bp_in_ready", bus_a.in_ready, 0);
    end
    bus_a.out_ready = 1;
    step();
    chk("bp_idle_ready", bus_a.in_ready, 1);
    chk("bp_valid_drop", bus_a.out_valid, 0);
    step();
    bus_a.in_valid = 0;
    track_word(7'b1111111, 7'b1111111, 4'b1111, 1'b0);
    step();

    // Loopback fault on serial bit 3
    fault_bit = 3;
    bus_a.in_valid = 1; bus_a.cw_in = 7'b1100110;
    step();
    bus_a.in_valid = 0;
    track_word(7'b1100110, 7'b1101110, 4'b1101, 1'b1);
    step();
    fault_bit = -1;

    // LSB-first instance
    bus_b.in_valid = 1; bus_b.cw_in = 7'b0000001;
    step();
    bus_b.in_valid = 0;
    chk("lsb_write", pts_write_b, 1);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk("lsb_shift", pts_shift_b, 1);
      chk("lsb_serial", serial_in_b, (c == 2));
    end
    step();
    chk("lsb_dec_enable", dec_enable_b, 1);
    chk("lsb_dec_codeword", dec_codeword_b, 7'b0000001);
    step();
    chk("lsb_out_valid", bus_b.out_valid, 1);
    chk("lsb_out_data", bus_b.out_data, 4'b0000);
    chk("lsb_link_err", bus_b.link_err, 0);
    step();
    chk("lsb_idle", busy_b, 0);

    // Flush mid-SHIFT
    bus_a.in_valid = 1; bus_a.cw_in = 7'b1001100;
    step();
    bus_a.in_valid = 0;
    step(); step(); step(); step();
    chk("fl_busy_before", busy_a, 1);
    flush = 1;
    step();
    flush = 0;
    chk("fl_in_ready", bus_a.in_ready, 1);
    chk("fl_pts_reset", pts_reset_a, 1);
    chk("fl_busy", busy_a, 0);
    chk("fl_out_data_kept", bus_a.out_data, 4'b1101);
    chk("fl_link_err_kept", bus_a.link_err, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fl_no_dec", dec_enable_a, 0);
      chk("fl_no_valid", bus_a.out_valid, 0);
    end
    // flush beats in_valid while idle
    bus_a.in_valid = 1; bus_a.cw_in = 7'b0110011; flush = 1;
    step();
    flush = 0;
    chk("fl_prio_idle", busy_a, 0);
    step();
    bus_a.in_valid = 0;
    track_word(7'b0110011, 7'b0110011, 4'b0110, 1'b0);
    step();

    // Back-to-back with in_valid held
    t0 = cyc;
    bus_a.in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bus_a.cw_in = b2b_cw[k];
      chk("b2b_accept_cyc", cyc - t0, 11 * k);
      chk("b2b_in_ready", bus_a.in_ready, 1);
      step();
      if (k == 3) bus_a.in_valid = 0;
      track_word(b2b_cw[k], b2b_cw[k], b2b_data[k], 1'b0);
      step();
    end

    // Reset in the middle of a word
    bus_a.in_valid = 1; bus_a.cw_in = 7'b1010101;
    step();
    bus_a.in_valid = 0;
    step(); step(); step();
    reset = 1;
    step();
    reset = 0;
    chk("mr_busy", busy_a, 0);
    chk("mr_out_data", bus_a.out_data, 0);
    chk("mr_link_err", bus_a.link_err, 0);
    chk("mr_pts_data", pts_data_a, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("mr_no_valid", bus_a.out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_rx_sequencer.md
Name: hamming_rx_sequencer

Overview:
Control sequencer for the receive-side Hamming(7,4) datapath. It accepts a 7-bit codeword on a valid/ready handshake and loads it into the parallel-to-serial shifter. It then clocks the codeword out bit by bit and reassembles the serial stream into a codeword register. Finally it enables the Hamming decoder for one cycle, latches the 4-bit decoded nibble and presents it on a valid/ready output. A loopback compare between the loaded and reassembled codeword flags serial-path faults.

Parameters:
CW_WIDTH, 7, codeword width; sets shift count and bit-counter range (counter width = clog2(CW_WIDTH)).
DATA_WIDTH, 4, decoded data width.
MSB_FIRST, 1, 1: serial stream carries bit CW_WIDTH-1 first; 0: bit 0 first.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous abort; returns the block to IDLE
in_valid  in  1  codeword available
in_ready  out  1  sequencer can accept a codeword
cw_in  in  CW_WIDTH  incoming codeword
pts_reset  out  1  clear to the parallel-to-serial shifter
pts_write  out  1  parallel load strobe to the shifter
pts_shift  out  1  shift strobe to the shifter
pts_data  out  CW_WIDTH  parallel data to the shifter (held codeword)
serial_in  in  1  shifter serial output, sampled by the sequencer
dec_enable  out  1  Hamming decoder enable
dec_codeword  out  CW_WIDTH  reassembled codeword driven to the decoder
dec_data  in  DATA_WIDTH  decoder output (combinational from dec_codeword)
out_valid  out  1  decoded nibble available
out_ready  in  1  consumer accepts the nibble
out_data  out  DATA_WIDTH  latched decoded nibble
link_err  out  1  reassembled codeword differs from the loaded codeword; valid with out_valid
busy  out  1  state != IDLE

Behaviour:
- All state and outputs are registered, except in_ready, busy, pts_write, pts_shift, pts_reset and dec_enable. These are decoded directly from the state register.
- Reset (reset=1 at an edge): state=IDLE, bit_cnt=0, cw_reg=0, asm_reg=0, out_data=0, link_err=0.
  - Outputs after reset: in_ready=1, pts_reset=1, pts_write=0, pts_shift=0, dec_enable=0, out_valid=0, busy=0.
- Reset asserted mid-operation overrides everything. It discards the word in flight and no output is produced.
- States:
  - IDLE: in_ready=1, pts_reset=1. If in_valid=1, then cw_reg<=cw_in and the next state is LOAD.
  - LOAD (1 cycle): pts_write=1, pts_data=cw_reg. bit_cnt<=0, then go to SHIFT.
  - SHIFT (CW_WIDTH cycles): pts_shift=1.
    - Each cycle, serial_in is stored into asm_reg.
    - MSB_FIRST=1: bit index CW_WIDTH-1-bit_cnt. MSB_FIRST=0: index bit_cnt.
    - bit_cnt increments. When bit_cnt==CW_WIDTH-1, go to DECODE.
  - DECODE (1 cycle): dec_enable=1, dec_codeword=asm_reg. At the edge: out_data<=dec_data, link_err<=(asm_reg!=cw_reg), out_valid<=1, then go to HOLD.
  - HOLD: out_valid=1, out_data and link_err held stable. If out_ready=1, then out_valid<=0 and go to IDLE.
- dec_codeword is driven from asm_reg in every state. It is meaningful only while dec_enable=1.
- Latency: accept edge at cycle 0 → LOAD cycle 1 → SHIFT cycles 2..8 → DECODE cycle 9 → out_valid=1 from cycle 10.
  - Throughput is 1 word per 11 cycles when out_ready is tied high (HOLD→IDLE costs 1 cycle).
- Backpressure: in_ready=0 in every state except IDLE. An in_valid held high during that time is not consumed.
- flush=1 at any edge: go to IDLE, out_valid<=0, bit_cnt<=0.
  - out_data and link_err keep their last values.
  - flush has priority over in_valid in IDLE, so no capture happens that cycle.
- Simultaneous reset and flush: reset wins (identical resulting state, plus out_data and link_err cleared).
- bit_cnt never exceeds CW_WIDTH-1. There is no wrap within a word.

Test Plan:
1. Reset, then one word: cw_in=7'b1010101 accepted at cycle 0, ideal loopback shifter model, out_ready=1. Required: pts_write high at cycle 1 only; pts_shift high cycles 2..8; dec_enable high at cycle 9 with dec_codeword=7'b1010101; out_valid=1 at cycle 10; out_data equals the decoder model output; link_err=0.
2. Backpressure: out_ready=0 for 5 cycles after out_valid. Required: out_valid, out_data and link_err stable; in_ready=0; a second in_valid is not captured until the cycle after the out_ready handshake.
3. Loopback fault: shifter model forces serial bit 3 inverted on 7'b1100110. Required: dec_codeword=7'b1101110 and link_err=1 with out_valid.
4. Bit order: MSB_FIRST=0, cw_in=7'b0000001, shifter model emits LSB first. Required: serial_in=1 sampled on SHIFT cycle 2 only; dec_codeword=7'b0000001.
5. Abort: flush=1 on cycle 5 (mid-SHIFT). Required: IDLE at cycle 6 with in_ready=1, pts_reset=1, no dec_enable, no out_valid. A new word then completes normally.
6. Back-to-back: 4 words with in_valid held and out_ready=1. Required: accepts at cycles 0, 11, 22, 33; 4 out_valid pulses in order with the correct nibbles.
